alarm_display_scan: RTL and testbench
=====================================

ALARM_DISPLAY_SCAN -- requirements
Module: alarm_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: Clock cycles each digit is driven (legal 2..65535).
REQ-002 SHALL have parameter BLINK_DIV, default 50: full 6-digit frames per blink-phase toggle (legal 1..255).
REQ-003 SHALL have port Clock  input  1  display scan clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Secs_C  input  6  current seconds, binary, from the clock stage.
REQ-006 SHALL have port Mins_C  input  6  current minutes, binary.
REQ-007 SHALL have port Hours_C  input  4  current hours, binary, 12-hour format.
REQ-008 SHALL have port AM_PM  input  1  0 = AM, 1 = PM.
REQ-009 SHALL have port Alarm  input  1  alarm active from the clock stage.
REQ-010 SHALL have port Digit_En  output  6  one-hot digit enable, active-high; bit 5 = hour tens, bit 0 = second units.
REQ-011 SHALL have port Seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-012 SHALL have port Dp  output  1  decimal point for the driven digit, active-high.
REQ-013 SHALL have port Buzzer  output  1  alarm sounder drive, active-high.

Function
REQ-014 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; the cycle where it equals SCAN_DIV-1 is the scan tick.
REQ-015 SHALL advance a digit index 0->1->2->3->4->5->0 on each scan tick, holding otherwise.
REQ-016 SHALL, on the scan tick where the index wraps 5->0, capture Secs_C, Mins_C, Hours_C, AM_PM and Alarm into a snapshot; every displayed digit within a frame comes from one snapshot.
REQ-017 SHALL count frames (index wraps) and toggle a blink phase bit when the count reaches BLINK_DIV, then clear the count.
REQ-018 SHALL register all outputs; outputs reflect the new index one Clock after the scan tick.
REQ-019 SHALL set Digit_En = one-hot of the registered index.
REQ-020 SHALL split each snapshot field into tens = value/10 and units = value mod 10, using compare-subtract logic, no divider IP.
REQ-021 SHALL encode digits 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex), dash as 40, blank as 00.
REQ-022 SHALL blank the hour-tens digit when hours are 1..9.
REQ-023 SHALL show dashes on both digits of any field out of range: seconds or minutes >59, hours 0 or >12.
REQ-024 SHALL drive Dp = 1 only on digit 0 and only when the snapshot AM_PM = 1; Dp = 1 on digit 2 and digit 4 always (separators).
REQ-025 SHALL, when snapshot Alarm = 1 and blink phase = 0, force Seg = 00 and Dp = 0 on all digits; Digit_En keeps scanning.
REQ-026 SHALL drive Buzzer = snapshot Alarm AND blink phase.
REQ-027 SHALL, when snapshot Alarm = 0, hold the blink phase at 1 and the frame count at 0, so the alarm always starts with a visible, sounding phase.
REQ-028 SHALL ignore input changes between snapshots; a change is shown at most one frame (6 x SCAN_DIV Clocks) later.

Reset
REQ-029 SHALL, while Reset = 0, asynchronously force prescaler = 0, index = 0, frame count = 0, blink phase = 1, snapshot = all zero.
REQ-030 SHALL, while Reset = 0, force Digit_En = 000001, Seg = 00, Dp = 0, Buzzer = 0.
REQ-031 SHALL, after Reset rises, capture the first snapshot at the first index wrap; until then, the zero snapshot (hours 0) shows dashes.
REQ-032 SHALL allow Reset assertion mid-frame or mid-blink with no partial state surviving.

Verification
REQ-033 SHALL cover: SCAN_DIV=4, inputs 12:34:56 AM, no alarm -> after the first wrap, one frame shows digits 5..0 = 06,5B,4F,66,6D,7D; Dp on digits 4 and 2 only; each Digit_En held 4 Clocks.
REQ-034 SHALL cover: 9:05:07 PM -> digit 5 = 00, digit 4 = 6F, digit 3 = 3F, digit 1 = 3F, digit 0 = 07 with Dp = 1.
REQ-035 SHALL cover: Hours_C = 0, Mins_C = 60 -> digits 5,4,3,2 = 40; seconds shown normally.
REQ-036 SHALL cover: SCAN_DIV=4, BLINK_DIV=2, Alarm=1 -> Buzzer = 1 and segments lit for 2 frames, then Seg = 00 and Buzzer = 0 for 2 frames, repeating; Alarm->0 -> normal display and Buzzer = 0 from the next frame.
REQ-037 SHALL cover: inputs changed mid-frame -> no mixed old/new digits within one frame.
REQ-038 SHALL cover: Reset pulsed low mid-frame while Alarm=1 -> immediate Digit_En = 000001, Seg = 00, Buzzer = 0; after release, the sequence restarts from prescaler 0.

Source files
------------

// File: rtl/alarm_display_scan.sv
// alarm_display_scan
//   Multiplexed 6-digit 7-segment scanner for a 12-hour alarm clock.
//   Each digit is driven for SCAN_DIV clocks. At every frame boundary
//   (digit index wrapping 5->0) the time and alarm inputs are captured
//   into a snapshot, so a frame never mixes old and new values. While
//   the snapshot alarm is active, the display and buzzer alternate
//   every BLINK_DIV frames, always starting in the visible/sounding phase.
//
// Ports
//   Clock    in   scan clock, rising edge active
//   Reset    in   asynchronous active-low reset
//   Secs_C   in   [5:0] seconds, binary
//   Mins_C   in   [5:0] minutes, binary
//   Hours_C  in   [3:0] hours, binary, 12-hour format
//   AM_PM    in   0 = AM, 1 = PM
//   Alarm    in   alarm active
//   Digit_En out  [5:0] one-hot digit enable (bit 5 = hour tens, bit 0 = second units)
//   Seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-high
//   Dp       out  decimal point of the driven digit
//   Buzzer   out  alarm sounder drive
module alarm_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Secs_C,
  input  logic [5:0] Mins_C,
  input  logic [3:0] Hours_C,
  input  logic       AM_PM,
  input  logic       Alarm,
  output logic [5:0] Digit_En,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       Buzzer
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_MAX = 8'(BLINK_DIV);
  localparam logic [6:0]  SEG_DASH  = 7'h40;

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_q, blink_d;
  logic [5:0]  secs_q, secs_d;
  logic [5:0]  mins_q, mins_d;
  logic [3:0]  hours_q, hours_d;
  logic        am_pm_q, am_pm_d;
  logic        alarm_q, alarm_d;
  logic [5:0]  digit_en_q, digit_en_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        buzzer_q, buzzer_d;

  logic        tick, wrap;
  logic [7:0]  sec_bcd, min_bcd, hr_bcd;
  logic        sec_ok, min_ok, hr_ok;

  // Binary 0..63 to {tens, units} by successive compare-subtract of 40/20/10.
  function automatic logic [7:0] split_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    secs_d      = secs_q;
    mins_d      = mins_q;
    hours_d     = hours_q;
    am_pm_d     = am_pm_q;
    alarm_d     = alarm_q;

    tick = (presc_q == PRESC_MAX);
    wrap = tick && (idx_q == 3'd5);

    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    if (wrap) begin
      secs_d  = Secs_C;
      mins_d  = Mins_C;
      hours_d = Hours_C;
      am_pm_d = AM_PM;
      alarm_d = Alarm;
      // Blink only runs across consecutive alarm frames; the first alarm
      // frame (old snapshot quiet) and any quiet frame restart it visible.
      if (!Alarm || !alarm_q) begin
        blink_d     = 1'b1;
        frame_cnt_d = 8'd0;
      end else if (frame_cnt_q + 8'd1 == BLINK_MAX) begin
        blink_d     = ~blink_q;
        frame_cnt_d = 8'd0;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // Outputs are decoded from next-state values so the registered outputs
    // always match the registered index and snapshot.
    sec_bcd = split_bcd(secs_d);
    min_bcd = split_bcd(mins_d);
    hr_bcd  = split_bcd({2'b00, hours_d});
    sec_ok  = (secs_d <= 6'd59);
    min_ok  = (mins_d <= 6'd59);
    hr_ok   = (hours_d != 4'd0) && (hours_d <= 4'd12);

    digit_en_d = 6'b000001 << idx_d;
    seg_d      = 7'h00;
    dp_d       = 1'b0;
    case (idx_d)
      3'd0: begin
        seg_d = sec_ok ? seg_of(sec_bcd[3:0]) : SEG_DASH;
        dp_d  = am_pm_d;
      end
      3'd1: seg_d = sec_ok ? seg_of(sec_bcd[7:4]) : SEG_DASH;
      3'd2: begin
        seg_d = min_ok ? seg_of(min_bcd[3:0]) : SEG_DASH;
        dp_d  = 1'b1;
      end
      3'd3: seg_d = min_ok ? seg_of(min_bcd[7:4]) : SEG_DASH;
      3'd4: begin
        seg_d = hr_ok ? seg_of(hr_bcd[3:0]) : SEG_DASH;
        dp_d  = 1'b1;
      end
      3'd5: begin
        if (!hr_ok)                seg_d = SEG_DASH;
        else if (hours_d >= 4'd10) seg_d = seg_of(hr_bcd[7:4]);
        else                       seg_d = 7'h00;
      end
      default: seg_d = 7'h00;
    endcase

    if (alarm_d && !blink_d) begin
      seg_d = 7'h00;
      dp_d  = 1'b0;
    end
    buzzer_d = alarm_d & blink_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q     <= 16'd0;
      idx_q       <= 3'd0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b1;
      secs_q      <= 6'd0;
      mins_q      <= 6'd0;
      hours_q     <= 4'd0;
      am_pm_q     <= 1'b0;
      alarm_q     <= 1'b0;
      digit_en_q  <= 6'b000001;
      seg_q       <= 7'h00;
      dp_q        <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      secs_q      <= secs_d;
      mins_q      <= mins_d;
      hours_q     <= hours_d;
      am_pm_q     <= am_pm_d;
      alarm_q     <= alarm_d;
      digit_en_q  <= digit_en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      buzzer_q    <= buzzer_d;
    end
  end

  assign Digit_En = digit_en_q;
  assign Seg      = seg_q;
  assign Dp       = dp_q;
  assign Buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_display_scan.sv
// Testbench for alarm_display_scan (SCAN_DIV=4, BLINK_DIV=2).
// A frame-level reference model predicts every output on every clock:
// digit index from elapsed clocks, digit values from the last frame-boundary
// snapshot via / and %, blink phase from the length of the current alarm run.
module tb_alarm_display_scan;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int FRAME = 6 * S;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] Secs_C, Mins_C;
  logic [3:0] Hours_C;
  logic       AM_PM, Alarm;
  logic [5:0] Digit_En;
  logic [6:0] Seg;
  logic       Dp, Buzzer;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int cyc;
  int m_secs, m_mins, m_hours, m_run;
  bit m_ampm, m_alarm;
  logic [6:0] enc [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  alarm_display_scan #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .Clock(Clock), .Reset(Reset), .Secs_C(Secs_C), .Mins_C(Mins_C),
    .Hours_C(Hours_C), .AM_PM(AM_PM), .Alarm(Alarm),
    .Digit_En(Digit_En), .Seg(Seg), .Dp(Dp), .Buzzer(Buzzer)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [6:0] digit_seg(int d, int s, int m, int h);
    int v;
    bit ok;
    case (d / 2)
      0:       begin v = s; ok = (s <= 59); end
      1:       begin v = m; ok = (m <= 59); end
      default: begin v = h; ok = (h >= 1 && h <= 12); end
    endcase
    if (!ok) return 7'h40;
    if (d % 2 == 0) return enc[v % 10];
    if (d == 5 && v < 10) return 7'h00;
    return enc[v / 10];
  endfunction

  task automatic check_model();
    int  idx;
    bit  blank;
    logic [6:0] e_seg;
    bit  e_dp;
    idx   = (cyc / S) % 6;
    blank = m_alarm && (((m_run - 1) / B) % 2 == 1);
    e_seg = blank ? 7'h00 : digit_seg(idx, m_secs, m_mins, m_hours);
    e_dp  = blank ? 1'b0 : ((idx == 0 && m_ampm) || idx == 2 || idx == 4);
    chk("digit_en", {2'b00, Digit_En}, 8'(1 << idx));
    chk("seg",      {1'b0, Seg},       {1'b0, e_seg});
    chk("dp",       {7'b0, Dp},        {7'b0, e_dp});
    chk("buzzer",   {7'b0, Buzzer},    {7'b0, (m_alarm && !blank)});
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge Clock);
      cyc++;
      if (cyc % FRAME == 0) begin
        m_secs  = int'(Secs_C);
        m_mins  = int'(Mins_C);
        m_hours = int'(Hours_C);
        m_ampm  = AM_PM;
        m_alarm = Alarm;
        m_run   = Alarm ? m_run + 1 : 0;
      end
      #1;
      check_model();
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_secs = 0; m_mins = 0; m_hours = 0;
    m_ampm = 1'b0; m_alarm = 1'b0; m_run = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},  {2'b00, Digit_En}, 8'h01);
    chk({tag, "_seg"}, {1'b0, Seg},       8'h00);
    chk({tag, "_dp"},  {7'b0, Dp},        8'h00);
    chk({tag, "_bz"},  {7'b0, Buzzer},    8'h00);
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit pm, input bit al);
    Hours_C = 4'(h); Mins_C = 6'(m); Secs_C = 6'(s); AM_PM = pm; Alarm = al;
  endtask

  task automatic align_frame();
    run((FRAME - (cyc % FRAME)) % FRAME);
  endtask

  initial begin
    model_reset();
    Reset = 1'b0;
    set_time(12, 34, 56, 1'b0, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs("reset_init");
    @(negedge Clock);
    Reset = 1'b1;

    // 12:34:56 AM; first frame shows the zero snapshot (dashed hours)
    run(48);
    chk("t1234_d0", {1'b0, Seg}, 8'h7D);
    chk("t1234_dp0", {7'b0, Dp}, 8'h00);
    run(4);
    chk("t1234_d1", {1'b0, Seg}, 8'h6D);
    run(4);
    chk("t1234_d2", {1'b0, Seg}, 8'h66);
    chk("t1234_dp2", {7'b0, Dp}, 8'h01);
    run(16);

    // 9:05:07 PM
    set_time(9, 5, 7, 1'b1, 1'b0);
    run(24);
    chk("t905_d0", {1'b0, Seg}, 8'h07);
    chk("t905_dp0", {7'b0, Dp}, 8'h01);
    run(4);
    chk("t905_d1", {1'b0, Seg}, 8'h3F);
    run(8);
    chk("t905_d3", {1'b0, Seg}, 8'h3F);
    run(4);
    chk("t905_d4", {1'b0, Seg}, 8'h6F);
    run(4);
    chk("t905_d5", {1'b0, Seg}, 8'h00);
    run(4);

    // out-of-range hours and minutes
    set_time(0, 60, 42, 1'b0, 1'b0);
    run(48);
    set_time(13, 59, 64, 1'b1, 1'b0);
    run(48);

    // random inputs changing mid-frame
    for (int i = 0; i < 40; i++) begin
      set_time($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      run($urandom_range(1, 30));
    end

    // alarm blink: two visible frames, two dark frames, repeating
    set_time(0, 0, 0, 1'b0, 1'b0);
    run(FRAME);
    align_frame();
    set_time(10, 20, 30, 1'b1, 1'b1);
    run(FRAME);
    chk("alarm_f1_bz", {7'b0, Buzzer}, 8'h01);
    run(2 * FRAME);
    chk("alarm_f3_bz", {7'b0, Buzzer}, 8'h00);
    chk("alarm_f3_seg", {1'b0, Seg}, 8'h00);
    run(7 * FRAME);
    set_time(10, 20, 30, 1'b1, 1'b0);
    run(2 * FRAME);

    // reset mid-frame while alarm sounding
    set_time(11, 11, 11, 1'b0, 1'b1);
    run(2 * FRAME + 10);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge Clock);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge Clock);
    model_reset();
    Reset = 1'b1;
    run(5 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
